// File: rtl/ps_sync_gen.sv
// Phase-staggered multi-channel sync clock generator for switching regulators.
// Period and phase changes are staged in shadow registers and applied only at a period boundary.
module ps_sync_gen #(
   parameter int NCH     = 3,
   parameter int DW      = 8,
   parameter int MIN_PER = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [DW-1:0]     cfg_period,
   input  logic [NCH*DW-1:0] cfg_phase,
   input  logic              cfg_strobe,
   output logic              cfg_pending,
   output logic [NCH-1:0]    ps_sync,
   output logic              frame,
   output logic              running
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [DW-1:0] MIN_P = DW'(MIN_PER);

   state_t        state;
   logic [DW-1:0] m;
   logic [DW-1:0] act_per;
   logic [DW-1:0] act_phase [NCH];
   logic [DW-1:0] sh_per;
   logic [DW-1:0] sh_phase  [NCH];

   logic [DW-1:0] raw_per;
   logic [DW-1:0] load_per;
   logic [DW-1:0] load_phase [NCH];
   logic [DW:0]   load_len;
   logic [DW:0]   act_len;
   logic [DW:0]   half_len;
   logic [NCH-1:0] hit;
   logic          wrap;

   // A strobe arriving together with the IDLE->RUN transition is applied directly at entry.
   always_comb begin
      raw_per  = (state == IDLE && cfg_strobe) ? cfg_period : sh_per;
      load_per = (raw_per < MIN_P) ? MIN_P : raw_per;
      load_len = {1'b0, load_per} + 1'b1;
      for (int i = 0; i < NCH; i++) begin
         load_phase[i] = (state == IDLE && cfg_strobe) ? cfg_phase[i*DW +: DW] : sh_phase[i];
         if ({1'b0, load_phase[i]} >= load_len) begin
            load_phase[i] = '0;
         end
      end
   end

   // Channel position wraps once at most because active phases are always below the period length.
   always_comb begin
      act_len  = {1'b0, act_per} + 1'b1;
      half_len = act_len >> 1;
      wrap     = (m == act_per);
      hit      = '0;
      for (int i = 0; i < NCH; i++) begin
         logic [DW:0] pos;
         pos = {1'b0, m} + {1'b0, act_phase[i]};
         if (pos >= act_len) begin
            pos = pos - act_len;
         end
         hit[i] = (pos < half_len);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         m           <= '0;
         act_per     <= MIN_P;
         sh_per      <= MIN_P;
         cfg_pending <= 1'b0;
         ps_sync     <= '0;
         frame       <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            act_phase[i] <= '0;
            sh_phase[i]  <= '0;
         end
      end else begin
         if (cfg_strobe) begin
            sh_per      <= cfg_period;
            cfg_pending <= 1'b1;
            for (int i = 0; i < NCH; i++) begin
               sh_phase[i] <= cfg_phase[i*DW +: DW];
            end
         end
         case (state)
            IDLE: begin
               ps_sync <= '0;
               frame   <= 1'b0;
               m       <= '0;
               if (enable) begin
                  state       <= RUN;
                  act_per     <= load_per;
                  act_phase   <= load_phase;
                  cfg_pending <= 1'b0;
               end
            end
            RUN: begin
               if (!enable) begin
                  state   <= IDLE;
                  m       <= '0;
                  ps_sync <= '0;
                  frame   <= 1'b0;
               end else begin
                  ps_sync <= hit;
                  frame   <= wrap;
                  if (wrap) begin
                     m <= '0;
                     // Only a strobe seen before this cycle is applied; one landing here waits a period.
                     if (cfg_pending) begin
                        act_per     <= load_per;
                        act_phase   <= load_phase;
                        cfg_pending <= cfg_strobe;
                     end
                  end else begin
                     m <= m + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign running = (state == RUN);

endmodule
